// File: rtl/alu_mon_pkg.sv
// Shared opcodes, monitor state encoding and the ALU golden model.
package alu_mon_pkg;

  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_CBZ  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_MOV  = 4'd13;

  localparam int MM_W = 68;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } monState_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] res;
    logic        carry;
  } golden_t;

  function automatic golden_t goldenModel(
    input logic [3:0]  code,
    input logic [31:0] a,
    input logic [31:0] b
  );
    golden_t g;
    logic [32:0] sum;
    g = '0;
    g.legal = 1'b1;
    sum = {1'b0, a} + {1'b0, b};
    case (code)
      OP_ADD: begin
        g.res = sum[31:0];
        g.carry = sum[32];
      end
      OP_SUB: begin
        g.res = a - b;
        g.carry = (a >= b);
      end
      OP_AND:  g.res = a & b;
      OP_OR:   g.res = a | b;
      OP_XOR:  g.res = a ^ b;
      OP_NOR:  g.res = ~(a | b);
      OP_NAND: g.res = ~(a & b);
      OP_CBZ:  g.res = b;
      OP_MOV:  g.res = b;
      default: g.legal = 1'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/alu_result_monitor_mm_fifo.sv
// Mismatch record FIFO; a push into a full FIFO succeeds only with a pop.
module mm_fifo
  import alu_mon_pkg::*;
#(
  parameter int W     = MM_W,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] pushData,
  output logic         popValid,
  input  logic         popReady,
  output logic [W-1:0] popData,
  output logic         full,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [W-1:0] mem [DEPTH];
  ptr_t wrPtr;
  ptr_t rdPtr;
  cnt_t count;
  logic doPop;
  logic doPush;

  assign full     = (count == cnt_t'(DEPTH));
  assign popValid = (count != '0);
  assign popData  = mem[rdPtr];
  assign doPop    = popValid && popReady;
  assign doPush   = push && (!full || doPop);

  always_ff @(posedge clock) begin
    if (doPush && !clear) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + ptr_t'(1);
      if (doPop) rdPtr <= rdPtr + ptr_t'(1);
      count <= count + cnt_t'(doPush) - cnt_t'(doPop);
      if (push && !doPush) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_monitor.sv
// ALU checker: golden model, latency alignment, counters, mismatch FIFO.
// Define CARRY_CHECK_EN to also compare the carry flag.
module alu_result_monitor
  import alu_mon_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int ERR_LIMIT  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [31:0]      read_data1,
  input  logic [31:0]      read_data2,
  input  logic [3:0]       alu_control_code,
  input  logic [31:0]      result,
  input  logic             zero_flag,
  input  logic             carry_bit,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] illegal_count,
  output logic             mm_valid,
  input  logic             mm_ready,
  output logic [MM_W-1:0]  mm_data,
  output logic             mm_overflow
);

  localparam int HD = LATENCY - 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  monState_e curState;
  golden_t   gold;

  logic        pipeValid [LATENCY];
  logic [3:0]  pipeCode  [LATENCY];
  logic [31:0] pipeExp   [LATENCY];
  logic        pipeZero  [LATENCY];
`ifdef CARRY_CHECK_EN
  logic        pipeCarry [LATENCY];
`else
  logic        unusedCarry;
  assign unusedCarry = carry_bit ^ gold.carry;
`endif

  logic active;
  logic checkNow;
  logic mismatch;
  logic pushRec;
  logic hitLimit;
  logic clearAll;
  logic fifoFull;

  assign gold = goldenModel(alu_control_code, read_data1, read_data2);
  assign state = curState;

  // Compares only happen on plain RUN cycles; start/stop discard in-flight ops.
  assign active   = (curState == ST_RUN) && !start && !stop;
  assign checkNow = active && pipeValid[HD];
`ifdef CARRY_CHECK_EN
  assign mismatch = (result != pipeExp[HD]) || (zero_flag != pipeZero[HD])
                 || (carry_bit != pipeCarry[HD]);
`else
  assign mismatch = (result != pipeExp[HD]) || (zero_flag != pipeZero[HD]);
`endif
  assign pushRec  = checkNow && mismatch;
  assign hitLimit = (ERR_LIMIT != 0) && pushRec
                 && (fail_count == CNT_W'(ERR_LIMIT - 1));
  assign clearAll = start && !stop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipeValid[i] <= 1'b0;
        pipeCode[i]  <= '0;
        pipeExp[i]   <= '0;
        pipeZero[i]  <= 1'b0;
`ifdef CARRY_CHECK_EN
        pipeCarry[i] <= 1'b0;
`endif
      end
    end else begin
      pipeValid[0] <= active && in_valid && gold.legal;
      pipeCode[0]  <= alu_control_code;
      pipeExp[0]   <= gold.res;
      pipeZero[0]  <= (gold.res == '0);
`ifdef CARRY_CHECK_EN
      pipeCarry[0] <= gold.carry;
`endif
      for (int i = 1; i < LATENCY; i++) begin
        pipeValid[i] <= active && pipeValid[i-1];
        pipeCode[i]  <= pipeCode[i-1];
        pipeExp[i]   <= pipeExp[i-1];
        pipeZero[i]  <= pipeZero[i-1];
`ifdef CARRY_CHECK_EN
        pipeCarry[i] <= pipeCarry[i-1];
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      curState      <= ST_IDLE;
      pass_count    <= '0;
      fail_count    <= '0;
      illegal_count <= '0;
    end else if (stop) begin
      curState <= ST_IDLE;
    end else if (start) begin
      curState      <= ST_RUN;
      pass_count    <= '0;
      fail_count    <= '0;
      illegal_count <= '0;
    end else if (curState == ST_RUN) begin
      if (in_valid && !gold.legal && illegal_count != CMAX)
        illegal_count <= illegal_count + 1'b1;
      if (checkNow) begin
        if (mismatch) begin
          if (fail_count != CMAX) fail_count <= fail_count + 1'b1;
          if (hitLimit) curState <= ST_HALT;
        end else if (pass_count != CMAX) begin
          pass_count <= pass_count + 1'b1;
        end
      end
    end
  end

  mm_fifo #(
    .W     (MM_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clearAll),
    .push     (pushRec),
    .pushData ({pipeCode[HD], pipeExp[HD], result}),
    .popValid (mm_valid),
    .popReady (mm_ready),
    .popData  (mm_data),
    .full     (fifoFull),
    .overflow (mm_overflow)
  );

  logic unusedFull;
  assign unusedFull = fifoFull;

endmodule
